// File: rtl/spi_frame_buffer_if.sv
// spi_frame_buffer_if: synchronizer ticks, FIFO access and status bundle for spi_frame_buffer
interface spi_frame_buffer_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic              spiBusy;
  logic              spiStart;
  logic              spiEnd;
  logic              spiTxLoad;
  logic              spiRxRdy;
  logic [DATA_W-1:0] spiRxData;
  logic [DATA_W-1:0] spiTxData;
  logic              rxRd;
  logic [DATA_W-1:0] rxData;
  logic              rxEmpty;
  logic [CW-1:0]     rxCnt;
  logic              txWr;
  logic [DATA_W-1:0] txWrData;
  logic              txFull;
  logic [CW-1:0]     txCnt;
  logic              rxOvf;
  logic              txUnd;
  logic              errClr;
  logic              frameDone;
  logic [15:0]       frameLen;
  modport master (
    output spiBusy, spiStart, spiEnd, spiTxLoad, spiRxRdy, spiRxData, rxRd, txWr, txWrData, errClr,
    input  spiTxData, rxData, rxEmpty, rxCnt, txFull, txCnt, rxOvf, txUnd, frameDone, frameLen
  );
  modport slave (
    input  spiBusy, spiStart, spiEnd, spiTxLoad, spiRxRdy, spiRxData, rxRd, txWr, txWrData, errClr,
    output spiTxData, rxData, rxEmpty, rxCnt, txFull, txCnt, rxOvf, txUnd, frameDone, frameLen
  );
endinterface

// File: rtl/spi_frame_buffer.sv
// spi_frame_buffer: RX/TX word FIFOs, TX staging register, error flags and frame tracking (frame length counter under SPI_FRAME_LEN_EN)
module spi_frame_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input logic               clk,
  input logic               reset,
  spi_frame_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [DATA_W-1:0] rx_mem_q [DEPTH];
  logic [DATA_W-1:0] tx_mem_q [DEPTH];
  logic [AW-1:0]     rx_wp_q, rx_rp_q, tx_wp_q, tx_rp_q;
  logic [CW-1:0]     rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [DATA_W-1:0] stage_q, stage_d;
  logic              stage_vld_q, stage_vld_d;
  logic              ovf_q, ovf_d, und_q, und_d;
  logic [1:0]        state_q, state_d;
  logic              rx_full, rx_push, rx_pop, tx_full, tx_empty, tx_push, tx_pop;

  // FIFO bookkeeping, staging refill, sticky errors and frame FSM next state
  always_comb begin
    rx_full     = rx_cnt_q == CW'(DEPTH);
    rx_pop      = bus.rxRd && rx_cnt_q != '0;
    rx_push     = bus.spiRxRdy && (!rx_full || bus.rxRd);
    rx_cnt_d    = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    tx_full     = tx_cnt_q == CW'(DEPTH);
    tx_empty    = tx_cnt_q == '0;
    tx_pop      = (!stage_vld_q || bus.spiTxLoad) && !tx_empty;
    tx_push     = bus.txWr && !tx_full;
    tx_cnt_d    = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    stage_d     = tx_pop ? tx_mem_q[tx_rp_q] : bus.spiTxLoad ? '0 : stage_q;
    stage_vld_d = tx_pop || (stage_vld_q && !bus.spiTxLoad);
    ovf_d       = !bus.errClr && (ovf_q || (bus.spiRxRdy && rx_full && !bus.rxRd));
    und_d       = !bus.errClr && (und_q || (bus.spiTxLoad && !stage_vld_q));
    state_d     = state_q == IDLE   ? (bus.spiStart ? ACTIVE : IDLE) :
                  state_q == ACTIVE ? (bus.spiStart ? ACTIVE : bus.spiEnd ? DONE : ACTIVE) :
                  IDLE;
  end

  // control state; reset drops FIFO contents by clearing pointers and counts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wp_q     <= '0;
      rx_rp_q     <= '0;
      rx_cnt_q    <= '0;
      tx_wp_q     <= '0;
      tx_rp_q     <= '0;
      tx_cnt_q    <= '0;
      stage_q     <= '0;
      stage_vld_q <= 1'b0;
      ovf_q       <= 1'b0;
      und_q       <= 1'b0;
      state_q     <= IDLE;
    end else begin
      rx_wp_q     <= rx_wp_q + AW'(rx_push);
      rx_rp_q     <= rx_rp_q + AW'(rx_pop);
      rx_cnt_q    <= rx_cnt_d;
      tx_wp_q     <= tx_wp_q + AW'(tx_push);
      tx_rp_q     <= tx_rp_q + AW'(tx_pop);
      tx_cnt_q    <= tx_cnt_d;
      stage_q     <= stage_d;
      stage_vld_q <= stage_vld_d;
      ovf_q       <= ovf_d;
      und_q       <= und_d;
      state_q     <= state_d;
    end
  end

  // storage arrays need no reset: pointers define what is valid
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wp_q] <= bus.spiRxData;
    if (tx_push) tx_mem_q[tx_wp_q] <= bus.txWrData;
  end

`ifdef SPI_FRAME_LEN_EN
  logic [15:0] len_q, len_d, flen_q;

  // words received in the current frame, saturating, cleared by every start
  always_comb len_d = bus.spiStart ? '0 :
                      (state_q == ACTIVE && bus.spiRxRdy && len_q != 16'hFFFF) ? len_q + 16'd1 : len_q;

  // count register and snapshot taken on the ACTIVE to DONE transition
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q  <= '0;
      flen_q <= '0;
    end else begin
      len_q  <= len_d;
      flen_q <= (state_q == ACTIVE && state_d == DONE) ? len_d : flen_q;
    end
  end

  assign bus.frameLen = flen_q;
`else
  assign bus.frameLen = '0;
`endif

  assign bus.spiTxData = stage_q;
  assign bus.rxData    = rx_mem_q[rx_rp_q];
  assign bus.rxEmpty   = rx_cnt_q == '0;
  assign bus.rxCnt     = rx_cnt_q;
  assign bus.txFull    = tx_full;
  assign bus.txCnt     = tx_cnt_q;
  assign bus.rxOvf     = ovf_q;
  assign bus.txUnd     = und_q;
  assign bus.frameDone = state_q == DONE;
endmodule

// File: tb/tb_spi_frame_buffer.sv
// tb_spi_frame_buffer: directed vector table plus overflow and mid-frame reset sequences
module tb_spi_frame_buffer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spi_frame_buffer_if #(.DATA_W(8), .DEPTH(16)) bus();
  spi_frame_buffer #(.DATA_W(8), .DEPTH(16)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic st, en, rdy; logic [7:0] rdat; logic rd, ld, wr; logic [7:0] wdat; logic clr;
    int cnt; logic [7:0] rhead; int tcnt; logic [7:0] tdat; logic ovf, und, done; logic [15:0] flen;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic st, logic en, logic rdy, logic [7:0] rdat, logic rd, logic ld,
                              logic wr, logic [7:0] wdat, logic clr, int cnt, logic [7:0] rhead,
                              int tcnt, logic [7:0] tdat, logic ovf, logic und, logic done, logic [15:0] flen);
    vec_t v;
    v.st = st; v.en = en; v.rdy = rdy; v.rdat = rdat; v.rd = rd; v.ld = ld; v.wr = wr; v.wdat = wdat;
    v.clr = clr; v.cnt = cnt; v.rhead = rhead; v.tcnt = tcnt; v.tdat = tdat; v.ovf = ovf; v.und = und;
    v.done = done; v.flen = flen;
    return v;
  endfunction

  function automatic logic [15:0] fl(int n);
`ifdef SPI_FRAME_LEN_EN
    return 16'(n);
`else
    return 16'(n - n);
`endif
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.spiBusy = 0; bus.spiStart = 0; bus.spiEnd = 0; bus.spiTxLoad = 0; bus.spiRxRdy = 0;
    bus.spiRxData = '0; bus.rxRd = 0; bus.txWr = 0; bus.txWrData = '0; bus.errClr = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, " rxCnt"}, 32'(bus.rxCnt), 0);
    chk({tag, " rxEmpty"}, 32'(bus.rxEmpty), 1);
    chk({tag, " txCnt"}, 32'(bus.txCnt), 0);
    chk({tag, " txFull"}, 32'(bus.txFull), 0);
    chk({tag, " spiTxData"}, 32'(bus.spiTxData), 0);
    chk({tag, " rxOvf"}, 32'(bus.rxOvf), 0);
    chk({tag, " txUnd"}, 32'(bus.txUnd), 0);
    chk({tag, " frameDone"}, 32'(bus.frameDone), 0);
    chk({tag, " frameLen"}, 32'(bus.frameLen), 0);
  endtask

  initial begin
    idle_inputs();
    // frame of 5 words, spiEnd in IDLE, RX drain incl. pop while empty
    tbl.push_back(mk(1,0,0,8'h00,0,0,0,8'h00,0, 0,8'h00,0,8'h00,0,0,0,fl(0)));
    tbl.push_back(mk(0,0,1,8'h11,0,0,0,8'h00,0, 1,8'h11,0,8'h00,0,0,0,fl(0)));
    tbl.push_back(mk(0,0,1,8'h22,0,0,0,8'h00,0, 2,8'h11,0,8'h00,0,0,0,fl(0)));
    tbl.push_back(mk(0,0,1,8'h33,0,0,0,8'h00,0, 3,8'h11,0,8'h00,0,0,0,fl(0)));
    tbl.push_back(mk(0,0,1,8'h44,0,0,0,8'h00,0, 4,8'h11,0,8'h00,0,0,0,fl(0)));
    tbl.push_back(mk(0,0,1,8'h55,0,0,0,8'h00,0, 5,8'h11,0,8'h00,0,0,0,fl(0)));
    tbl.push_back(mk(0,1,0,8'h00,0,0,0,8'h00,0, 5,8'h11,0,8'h00,0,0,1,fl(5)));
    tbl.push_back(mk(0,0,0,8'h00,0,0,0,8'h00,0, 5,8'h11,0,8'h00,0,0,0,fl(5)));
    tbl.push_back(mk(0,1,0,8'h00,0,0,0,8'h00,0, 5,8'h11,0,8'h00,0,0,0,fl(5)));
    tbl.push_back(mk(0,0,0,8'h00,0,0,0,8'h00,0, 5,8'h11,0,8'h00,0,0,0,fl(5)));
    tbl.push_back(mk(0,0,0,8'h00,1,0,0,8'h00,0, 4,8'h22,0,8'h00,0,0,0,fl(5)));
    tbl.push_back(mk(0,0,0,8'h00,1,0,0,8'h00,0, 3,8'h33,0,8'h00,0,0,0,fl(5)));
    tbl.push_back(mk(0,0,0,8'h00,1,0,0,8'h00,0, 2,8'h44,0,8'h00,0,0,0,fl(5)));
    tbl.push_back(mk(0,0,0,8'h00,1,0,0,8'h00,0, 1,8'h55,0,8'h00,0,0,0,fl(5)));
    tbl.push_back(mk(0,0,0,8'h00,1,0,0,8'h00,0, 0,8'h00,0,8'h00,0,0,0,fl(5)));
    tbl.push_back(mk(0,0,0,8'h00,1,0,0,8'h00,0, 0,8'h00,0,8'h00,0,0,0,fl(5)));
    // restart inside ACTIVE after 3 words, then 2 words
    tbl.push_back(mk(1,0,0,8'h00,0,0,0,8'h00,0, 0,8'h00,0,8'h00,0,0,0,fl(5)));
    tbl.push_back(mk(0,0,1,8'h66,0,0,0,8'h00,0, 1,8'h66,0,8'h00,0,0,0,fl(5)));
    tbl.push_back(mk(0,0,1,8'h77,0,0,0,8'h00,0, 2,8'h66,0,8'h00,0,0,0,fl(5)));
    tbl.push_back(mk(0,0,1,8'h88,0,0,0,8'h00,0, 3,8'h66,0,8'h00,0,0,0,fl(5)));
    tbl.push_back(mk(1,0,0,8'h00,0,0,0,8'h00,0, 3,8'h66,0,8'h00,0,0,0,fl(5)));
    tbl.push_back(mk(0,0,1,8'h99,0,0,0,8'h00,0, 4,8'h66,0,8'h00,0,0,0,fl(5)));
    tbl.push_back(mk(0,0,1,8'hAA,0,0,0,8'h00,0, 5,8'h66,0,8'h00,0,0,0,fl(5)));
    tbl.push_back(mk(0,1,0,8'h00,0,0,0,8'h00,0, 5,8'h66,0,8'h00,0,0,1,fl(2)));
    tbl.push_back(mk(0,0,0,8'h00,0,0,0,8'h00,0, 5,8'h66,0,8'h00,0,0,0,fl(2)));
    tbl.push_back(mk(0,0,0,8'h00,1,0,0,8'h00,0, 4,8'h77,0,8'h00,0,0,0,fl(2)));
    tbl.push_back(mk(0,0,0,8'h00,1,0,0,8'h00,0, 3,8'h88,0,8'h00,0,0,0,fl(2)));
    tbl.push_back(mk(0,0,0,8'h00,1,0,0,8'h00,0, 2,8'h99,0,8'h00,0,0,0,fl(2)));
    tbl.push_back(mk(0,0,0,8'h00,1,0,0,8'h00,0, 1,8'hAA,0,8'h00,0,0,0,fl(2)));
    tbl.push_back(mk(0,0,0,8'h00,1,0,0,8'h00,0, 0,8'h00,0,8'h00,0,0,0,fl(2)));
    // TX staging: A5, 3C, then three loads; underrun and errClr priority
    tbl.push_back(mk(0,0,0,8'h00,0,0,1,8'hA5,0, 0,8'h00,1,8'h00,0,0,0,fl(2)));
    tbl.push_back(mk(0,0,0,8'h00,0,0,1,8'h3C,0, 0,8'h00,1,8'hA5,0,0,0,fl(2)));
    tbl.push_back(mk(0,0,0,8'h00,0,0,0,8'h00,0, 0,8'h00,1,8'hA5,0,0,0,fl(2)));
    tbl.push_back(mk(0,0,0,8'h00,0,1,0,8'h00,0, 0,8'h00,0,8'h3C,0,0,0,fl(2)));
    tbl.push_back(mk(0,0,0,8'h00,0,1,0,8'h00,0, 0,8'h00,0,8'h00,0,0,0,fl(2)));
    tbl.push_back(mk(0,0,0,8'h00,0,1,0,8'h00,0, 0,8'h00,0,8'h00,0,1,0,fl(2)));
    tbl.push_back(mk(0,0,0,8'h00,0,0,0,8'h00,1, 0,8'h00,0,8'h00,0,0,0,fl(2)));
    tbl.push_back(mk(0,0,0,8'h00,0,1,0,8'h00,1, 0,8'h00,0,8'h00,0,0,0,fl(2)));
    tbl.push_back(mk(0,0,0,8'h00,0,0,0,8'h00,0, 0,8'h00,0,8'h00,0,0,0,fl(2)));

    #3;
    chk_reset_vals("por");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;

    foreach (tbl[i]) begin
      string t;
      t = $sformatf("v%0d", i);
      bus.spiStart = tbl[i].st; bus.spiEnd = tbl[i].en; bus.spiRxRdy = tbl[i].rdy;
      bus.spiRxData = tbl[i].rdat; bus.rxRd = tbl[i].rd; bus.spiTxLoad = tbl[i].ld;
      bus.txWr = tbl[i].wr; bus.txWrData = tbl[i].wdat; bus.errClr = tbl[i].clr;
      step();
      chk({t, " rxCnt"}, 32'(bus.rxCnt), 32'(tbl[i].cnt));
      chk({t, " rxEmpty"}, 32'(bus.rxEmpty), 32'(tbl[i].cnt == 0));
      if (tbl[i].cnt != 0) chk({t, " rxData"}, 32'(bus.rxData), 32'(tbl[i].rhead));
      chk({t, " txCnt"}, 32'(bus.txCnt), 32'(tbl[i].tcnt));
      chk({t, " txFull"}, 32'(bus.txFull), 32'(tbl[i].tcnt == 16));
      chk({t, " spiTxData"}, 32'(bus.spiTxData), 32'(tbl[i].tdat));
      chk({t, " rxOvf"}, 32'(bus.rxOvf), 32'(tbl[i].ovf));
      chk({t, " txUnd"}, 32'(bus.txUnd), 32'(tbl[i].und));
      chk({t, " frameDone"}, 32'(bus.frameDone), 32'(tbl[i].done));
      chk({t, " frameLen"}, 32'(bus.frameLen), 32'(tbl[i].flen));
    end

    // RX overflow: 17 pushes into a 16-deep FIFO, last word 0x10 dropped
    for (int i = 0; i < 17; i++) begin
      bus.spiRxRdy = 1; bus.spiRxData = 8'(i);
      step();
    end
    chk("ovf rxCnt", 32'(bus.rxCnt), 16);
    chk("ovf rxOvf", 32'(bus.rxOvf), 1);
    chk("ovf head", 32'(bus.rxData), 0);
    bus.errClr = 1;
    step();
    chk("ovf clr", 32'(bus.rxOvf), 0);
    bus.rxRd = 1; bus.spiRxRdy = 1; bus.spiRxData = 8'hEE;
    step();
    chk("full rd+rdy rxCnt", 32'(bus.rxCnt), 16);
    chk("full rd+rdy rxOvf", 32'(bus.rxOvf), 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d", i), 32'(bus.rxData), (i < 15) ? 32'(i + 1) : 32'hEE);
      bus.rxRd = 1;
      step();
    end
    chk("drain rxCnt", 32'(bus.rxCnt), 0);
    chk("drain rxEmpty", 32'(bus.rxEmpty), 1);

    // mid-frame reset with RX words, staged TX word and txUnd set
    bus.spiStart = 1; step();
    bus.spiRxRdy = 1; bus.spiRxData = 8'h01; step();
    bus.spiRxRdy = 1; bus.spiRxData = 8'h02; step();
    bus.spiTxLoad = 1; step();
    bus.txWr = 1; bus.txWrData = 8'h5A; step();
    step();
    chk("pre rxCnt", 32'(bus.rxCnt), 2);
    chk("pre txUnd", 32'(bus.txUnd), 1);
    chk("pre spiTxData", 32'(bus.spiTxData), 32'h5A);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    reset = 1'b0;
    #1;
    bus.spiRxRdy = 1; bus.spiRxData = 8'h07; step();
    chk("post rxCnt", 32'(bus.rxCnt), 1);
    chk("post rxData", 32'(bus.rxData), 32'h07);
    bus.spiEnd = 1; step();
    chk("post frameDone", 32'(bus.frameDone), 0);
    chk("post frameLen", 32'(bus.frameLen), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
